// File: rtl/fibonacci_gen_pkg.sv
// Shared definitions for the Fibonacci term generator: FSM state encoding
// and the default datapath width.
package fibonacci_gen_pkg;

    localparam int FIB_DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } fib_state_e;

endpackage : fibonacci_gen_pkg

// File: rtl/fibonacci_gen.sv
// Iterative Fibonacci generator: computes F(n) mod 2^WIDTH, one iteration
// per clock, and reports completion with a single-cycle done pulse.
module fibonacci_gen
    import fibonacci_gen_pkg::*;
#(
    parameter int WIDTH = FIB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] fib,
    output logic             busy,
    output logic             done
);

    fib_state_e       state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] fib_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_d;

    // The single adder of the datapath; wrap-around is intentional.
    assign sum_d = a_q + b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fib_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= n;
                        a_q     <= '0;
                        b_q     <= WIDTH'(1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q != '0) begin
                        a_q   <= b_q;
                        b_q   <= sum_d;
                        cnt_q <= cnt_q - WIDTH'(1);
                    end else begin
                        fib_q   <= a_q;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fib  = fib_q;
    assign done = done_q;
    assign busy = (state_q == CALC);

endmodule : fibonacci_gen

// File: tb/tb_fibonacci_gen.sv
// Self-checking bench for fibonacci_gen: directed scenarios plus randomized
// runs checked against a precomputed table of Fibonacci terms mod 2^8.
module tb_fibonacci_gen;

    localparam int W      = 8;
    localparam int BUDGET = 300;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] n     = '0;
    logic [W-1:0] fib;
    logic         busy;
    logic         done;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [W-1:0] fibTable [0:255];

    fibonacci_gen #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .n    (n),
        .fib  (fib),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Starts one run and measures cycles from the accept edge to done.
    // viol counts cycles where busy/fib/done misbehave around the run.
    task automatic run_calc(input logic [W-1:0] nv, output int lat,
                            output logic [W-1:0] res, output int viol);
        logic [W-1:0] prevFib;
        @(negedge clk);
        start   = 1'b1;
        n       = nv;
        prevFib = fib;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = W'($urandom);
        lat   = -1;
        res   = 'x;
        viol  = 0;
        if (busy !== 1'b1 || done !== 1'b0 || fib !== prevFib) viol++;
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = c;
                res = fib;
                if (busy !== 1'b0) viol++;
                break;
            end
            if (busy !== 1'b1 || fib !== prevFib) viol++;
        end
        @(posedge clk);
        #1;
        if (done !== 1'b0 || busy !== 1'b0 || (lat > 0 && fib !== res)) viol++;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        testsRun++;
        if (fib !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: fib=%0d busy=%b done=%b, expected 0/0/0", fib, busy, done);
        end
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (fib !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: fib=%0d busy=%b done=%b, expected 0/0/0", fib, busy, done);
        end
        start = 1'b0;
    endtask

    // Release reset and start on the same cycle: the very first edge with
    // rst high must accept the request.
    task automatic test_n0();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        n     = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        testsRun++;
        if (busy !== 1'b1 || done !== 1'b0 || fib !== '0) begin
            testsFailed++;
            $display("[TB] FAIL n0_accept: busy=%b done=%b fib=%0d, expected 1/0/0", busy, done, fib);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (done !== 1'b1 || fib !== '0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL n0_done: done=%b fib=%0d busy=%b, expected 1/0/0", done, fib, busy);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL n0_pulse: done=%b, expected 0", done);
        end
    endtask

    task automatic test_directed();
        int           lat;
        int           viol;
        logic [W-1:0] res;
        int           nList   [5] = '{1, 10, 13, 14, 20};
        int           expList [5] = '{1, 55, 233, 121, 109};
        foreach (nList[i]) begin
            run_calc(W'(nList[i]), lat, res, viol);
            testsRun++;
            if (lat !== nList[i] + 1) begin
                testsFailed++;
                $display("[TB] FAIL latency_n%0d: got %0d cycles, expected %0d", nList[i], lat, nList[i] + 1);
            end
            testsRun++;
            if (res !== W'(expList[i])) begin
                testsFailed++;
                $display("[TB] FAIL result_n%0d: fib=%0d, expected %0d", nList[i], res, expList[i]);
            end
            testsRun++;
            if (viol !== 0) begin
                testsFailed++;
                $display("[TB] FAIL busy_hold_n%0d: %0d bad cycles, expected 0", nList[i], viol);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        @(negedge clk);
        start = 1'b1;
        n     = W'(10);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b1;
        n     = W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 3; c <= BUDGET; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        testsRun++;
        if (lat !== 11 || fib !== W'(55)) begin
            testsFailed++;
            $display("[TB] FAIL ignore_start: lat=%0d fib=%0d, expected 11/55", lat, fib);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ignore_no_queue: busy=%b done=%b, expected 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int           lat;
        int           viol;
        int           badCycles = 0;
        logic [W-1:0] res;
        @(negedge clk);
        start = 1'b1;
        n     = W'(12);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        testsRun++;
        if (busy !== 1'b0 || fib !== '0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid: busy=%b fib=%0d done=%b, expected 0/0/0", busy, fib, done);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) badCycles++;
        end
        testsRun++;
        if (badCycles !== 0) begin
            testsFailed++;
            $display("[TB] FAIL reset_wait_idle: %0d bad cycles, expected 0", badCycles);
        end
        run_calc(W'(7), lat, res, viol);
        testsRun++;
        if (lat !== 8 || res !== W'(13) || viol !== 0) begin
            testsFailed++;
            $display("[TB] FAIL after_reset_n7: lat=%0d fib=%0d viol=%0d, expected 8/13/0", lat, res, viol);
        end
    endtask

    // start held high: one IDLE cycle (the done cycle) between runs.
    task automatic test_back_to_back();
        int nA   = $urandom_range(0, 15);
        int nB   = $urandom_range(0, 15);
        int latA = -1;
        int latB = -1;
        @(negedge clk);
        start = 1'b1;
        n     = W'(nA);
        @(posedge clk);
        #1;
        n = W'(nB);
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                latA = c;
                break;
            end
        end
        testsRun++;
        if (latA !== nA + 1 || fib !== fibTable[nA]) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first_n%0d: lat=%0d fib=%0d, expected %0d/%0d", nA, latA, fib, nA + 1, fibTable[nA]);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        testsRun++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_restart: busy=%b done=%b, expected 1/0", busy, done);
        end
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                latB = c;
                break;
            end
        end
        testsRun++;
        if (latB !== nB + 1 || fib !== fibTable[nB]) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second_n%0d: lat=%0d fib=%0d, expected %0d/%0d", nB, latB, fib, nB + 1, fibTable[nB]);
        end
    endtask

    task automatic test_random();
        int           lat;
        int           viol;
        logic [W-1:0] res;
        for (int i = 0; i < 10; i++) begin
            int nv = (i == 9) ? 255 : $urandom_range(0, 40);
            run_calc(W'(nv), lat, res, viol);
            testsRun++;
            if (lat !== nv + 1 || res !== fibTable[nv] || viol !== 0) begin
                testsFailed++;
                $display("[TB] FAIL random_n%0d: lat=%0d fib=%0d viol=%0d, expected %0d/%0d/0", nv, lat, res, viol, nv + 1, fibTable[nv]);
            end
        end
    endtask

    initial begin
        fibTable[0] = '0;
        fibTable[1] = W'(1);
        for (int k = 2; k < 256; k++) fibTable[k] = fibTable[k-1] + fibTable[k-2];

        test_reset();
        test_n0();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_fibonacci_gen
